// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the shared flash arbiter
package arb_pkg;

   localparam int N_PORTS = 3;
   localparam int ID_W    = $clog2(N_PORTS);
   localparam int CNT_W   = $clog2(N_PORTS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - FIFO of requester IDs, each ID held at most once
module arb_id_fifo
   import arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_PORTS-1:0] push,
   input  logic               pop,
   output logic [ID_W-1:0]    head,
   output logic               empty,
   output logic [N_PORTS-1:0] member
);

   logic [ID_W-1:0]    q     [N_PORTS];
   logic [ID_W-1:0]    nxt_q [N_PORTS];
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   nxt_cnt;
   logic [N_PORTS-1:0] nxt_member;

   always_comb begin
      nxt_q      = q;
      nxt_cnt    = cnt;
      nxt_member = member;
      if (pop && cnt != '0) begin
         nxt_member[q[0]] = 1'b0;
         for (int k = 0; k < N_PORTS - 1; k++) begin
            nxt_q[k] = q[k+1];
         end
         nxt_q[N_PORTS-1] = '0;
         nxt_cnt          = cnt - 1'b1;
      end
      // Ascending scan: simultaneous arrivals take slots in index order.
      for (int i = 0; i < N_PORTS; i++) begin
         if (push[i] && !nxt_member[i] && nxt_cnt < CNT_W'(N_PORTS)) begin
            nxt_q[nxt_cnt[ID_W-1:0]] = ID_W'(i);
            nxt_member[i]            = 1'b1;
            nxt_cnt                  = nxt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < N_PORTS; k++) begin
            q[k] <= '0;
         end
         cnt    <= '0;
         member <= '0;
      end else begin
         q      <= nxt_q;
         cnt    <= nxt_cnt;
         member <= nxt_member;
      end
   end

   assign head  = q[0];
   assign empty = (cnt == '0);

endmodule

// File: rtl/shared_flash_arbiter.sv
// rtl/shared_flash_arbiter.sv - FIFO-ordered session arbiter in front of one flash reader
module shared_flash_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 8,
   parameter int N_PORTS = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_PORTS-1:0]        req,
   output logic [N_PORTS-1:0]        grant,
   input  logic [N_PORTS*ADDR_W-1:0] p_addr,
   input  logic [N_PORTS-1:0]        p_rd,
   output logic [N_PORTS-1:0]        p_valid,
   output logic [DATA_W-1:0]         rd_data,
   output logic [ADDR_W-1:0]         res_addr,
   output logic                      res_rd,
   input  logic [DATA_W-1:0]         res_data,
   input  logic                      res_valid,
   input  logic                      res_busy
);

   import arb_pkg::*;

   arb_state_t         state;
   logic [ID_W-1:0]    head;
   logic               empty;
   logic [N_PORTS-1:0] member;
   logic [N_PORTS-1:0] push;
   logic               pop;
   logic               head_req;

   // The owner stays at the FIFO head for its whole session, so it cannot re-queue until popped.
   assign head_req = req[head];
   assign push     = req & ~member & ~grant;

   always_comb begin
      pop = 1'b0;
      if (state == IDLE) begin
         pop = !empty && !head_req;
      end else if (state == GRANT) begin
         pop = !head_req;
      end
   end

   arb_id_fifo u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .pop    (pop),
      .head   (head),
      .empty  (empty),
      .member (member)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty && head_req && !res_busy) begin
                  grant <= N_PORTS'(1) << head;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (!head_req) begin
                  grant <= '0;
                  state <= GAP;
               end
            end
            GAP: begin
               if (!res_busy) begin
                  state <= IDLE;
               end
            end
            default: begin
               grant <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      res_addr = '0;
      res_rd   = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (grant[i]) begin
            res_addr = p_addr[i*ADDR_W +: ADDR_W];
            res_rd   = p_rd[i];
         end
      end
   end

   assign p_valid = grant & {N_PORTS{res_valid}};
   assign rd_data = res_data;

endmodule

// File: tb/tb_shared_flash_arbiter.sv
// tb/tb_shared_flash_arbiter.sv - scoreboard bench for shared_flash_arbiter
module tb_shared_flash_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req;
   logic [2:0]  grant;
   logic [71:0] p_addr;
   logic [2:0]  p_rd;
   logic [2:0]  p_valid;
   logic [7:0]  rd_data;
   logic [23:0] res_addr;
   logic        res_rd;
   logic [7:0]  res_data;
   logic        res_valid;
   logic        res_busy;

   int checks = 0;
   int passed = 0;
   int multi_hot = 0;
   int exp_q[$];

   shared_flash_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant     (grant),
      .p_addr    (p_addr),
      .p_rd      (p_rd),
      .p_valid   (p_valid),
      .rd_data   (rd_data),
      .res_addr  (res_addr),
      .res_rd    (res_rd),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_busy  (res_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && $countones(grant) > 1) multi_hot++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_grant(output logic [2:0] g, output int zeros);
      g = 3'b000;
      zeros = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (grant !== 3'b000) begin
            g = grant;
            return;
         end
         zeros++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req = 3'b111; p_rd = 3'b111; res_valid = 1'b1; res_busy = 1'b0;
      res_data = 8'h00; p_addr = {24'h000003, 24'h000002, 24'h000001};
      repeat (3) @(negedge clk);
      checks++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant); else passed++;
      checks++; if (p_valid !== 3'b000) $display("FAIL reset_p_valid: got %b want 000", p_valid); else passed++;
      checks++; if (res_rd !== 1'b0) $display("FAIL reset_res_rd: got %b want 0", res_rd); else passed++;
      checks++; if (res_addr !== 24'h0) $display("FAIL reset_res_addr: got %h want 000000", res_addr); else passed++;
      rst_n = 1'b1; req = 3'b000; p_rd = 3'b000; res_valid = 1'b0; p_addr = '0;
      @(negedge clk);
   endtask

   task automatic test_single;
      int e;
      logic [2:0] expg;
      req = 3'b010; p_addr[47:24] = 24'h000100; exp_q.push_back(1);
      @(negedge clk);
      checks++; if (grant !== 3'b000) $display("FAIL single_latency: got %b want 000", grant); else passed++;
      @(negedge clk);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (grant !== expg) $display("FAIL single_grant: got %b want %b", grant, expg); else passed++;
      checks++; if (res_addr !== 24'h000100) $display("FAIL single_addr: got %h want 000100", res_addr); else passed++;
      p_rd = 3'b101; #1;
      checks++; if (res_rd !== 1'b0) $display("FAIL foreign_rd: got %b want 0", res_rd); else passed++;
      p_rd = 3'b010; #1;
      checks++; if (res_rd !== 1'b1) $display("FAIL owner_rd: got %b want 1", res_rd); else passed++;
      res_valid = 1'b1; res_data = 8'hA5; #1;
      checks++; if (p_valid !== 3'b010) $display("FAIL single_valid: got %b want 010", p_valid); else passed++;
      checks++; if (rd_data !== 8'hA5) $display("FAIL single_data: got %h want a5", rd_data); else passed++;
      req = 3'b000; p_rd = 3'b000;
      @(negedge clk);
      checks++; if (grant !== 3'b000) $display("FAIL release_grant: got %b want 000", grant); else passed++;
      checks++; if (p_valid !== 3'b000) $display("FAIL gap_valid: got %b want 000", p_valid); else passed++;
      checks++; if (res_addr !== 24'h0) $display("FAIL gap_addr: got %h want 000000", res_addr); else passed++;
      res_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_all_three;
      int e, z;
      logic [2:0] g, expg;
      req = 3'b111; exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      for (int n = 0; n < 3; n++) begin
         wait_grant(g, z);
         e = exp_q.pop_front(); expg = 3'b001 << e;
         checks++; if (g !== expg) $display("FAIL order_grant%0d: got %b want %b", n, g, expg); else passed++;
         if (n > 0) begin
            checks++; if (z < 1) $display("FAIL order_gap%0d: zero cycles %0d want >=1", n, z); else passed++;
         end
         @(negedge clk);
         req = req & ~g;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_atomic;
      int e, z;
      bit viol;
      logic [2:0] g, expg;
      req = 3'b101; exp_q.push_back(0); exp_q.push_back(2);
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL atomic_first: got %b want %b", g, expg); else passed++;
      viol = 1'b0;
      p_addr[23:0] = 24'h000010;
      for (int k = 0; k < 2; k++) begin
         p_rd = 3'b001; #1;
         checks++; if (res_rd !== 1'b1 || res_addr !== 24'h000010)
            $display("FAIL atomic_cmd%0d: rd=%b addr=%h want 1/000010", k, res_rd, res_addr); else passed++;
         @(negedge clk);
         if (grant[2]) viol = 1'b1;
         p_rd = 3'b000; res_valid = 1'b1; res_data = 8'h5A; #1;
         checks++; if (p_valid !== 3'b001) $display("FAIL atomic_valid%0d: got %b want 001", k, p_valid); else passed++;
         @(negedge clk);
         if (grant[2]) viol = 1'b1;
         res_valid = 1'b0;
      end
      checks++; if (viol || grant !== 3'b001) $display("FAIL atomic_hold: grant=%b viol=%0d want 001/0", grant, viol); else passed++;
      req = 3'b100;
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL atomic_next: got %b want %b", g, expg); else passed++;
      @(negedge clk);
      req = 3'b000;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_busy;
      int e, z;
      bit viol;
      logic [2:0] g, expg;
      req = 3'b110; exp_q.push_back(1); exp_q.push_back(2);
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL busy_first: got %b want %b", g, expg); else passed++;
      @(negedge clk);
      req = 3'b100; res_busy = 1'b1;
      viol = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (grant !== 3'b000) viol = 1'b1;
      end
      checks++; if (viol) $display("FAIL busy_hold: got grant during busy, want none"); else passed++;
      res_busy = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 3'b000) $display("FAIL busy_edge: got %b want 000", grant); else passed++;
      @(negedge clk);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (grant !== expg) $display("FAIL busy_grant: got %b want %b", grant, expg); else passed++;
      req = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_withdraw;
      int e, z;
      logic [2:0] g, expg;
      req = 3'b111; exp_q.push_back(0); exp_q.push_back(2);
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL withdraw_first: got %b want %b", g, expg); else passed++;
      @(negedge clk);
      req = 3'b101;
      @(negedge clk);
      req = 3'b100;
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL withdraw_skip: got %b want %b", g, expg); else passed++;
      @(negedge clk);
      req = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int e, z;
      logic [2:0] g, expg;
      req = 3'b011; exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL b2b_first: got %b want %b", g, expg); else passed++;
      @(negedge clk);
      req = 3'b010;
      @(negedge clk);
      req = 3'b011;
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL b2b_fair: got %b want %b", g, expg); else passed++;
      @(negedge clk);
      req = 3'b001;
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL b2b_requeue: got %b want %b", g, expg); else passed++;
      @(negedge clk);
      req = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int e, z;
      logic [2:0] g, expg;
      req = 3'b001; exp_q.push_back(0);
      wait_grant(g, z);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (g !== expg) $display("FAIL rstmid_first: got %b want %b", g, expg); else passed++;
      p_rd = 3'b001; p_addr[23:0] = 24'hABCDEF; #1;
      checks++; if (res_rd !== 1'b1) $display("FAIL rstmid_rd: got %b want 1", res_rd); else passed++;
      req = 3'b011; rst_n = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 3'b000) $display("FAIL rstmid_grant: got %b want 000", grant); else passed++;
      checks++; if (res_rd !== 1'b0 || res_addr !== 24'h0)
         $display("FAIL rstmid_res: rd=%b addr=%h want 0/000000", res_rd, res_addr); else passed++;
      checks++; if (dut.u_fifo.empty !== 1'b1) $display("FAIL rstmid_fifo: empty=%b want 1", dut.u_fifo.empty); else passed++;
      rst_n = 1'b1; exp_q.push_back(0);
      @(negedge clk);
      checks++; if (grant !== 3'b000) $display("FAIL rstmid_reenq: got %b want 000", grant); else passed++;
      @(negedge clk);
      e = exp_q.pop_front(); expg = 3'b001 << e;
      checks++; if (grant !== expg) $display("FAIL rstmid_regrant: got %b want %b", grant, expg); else passed++;
      req = 3'b000; p_rd = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_single;
      test_all_three;
      test_atomic;
      test_busy;
      test_withdraw;
      test_back_to_back;
      test_reset_mid;
      checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); else passed++;
      checks++; if (multi_hot != 0) $display("FAIL one_hot: %0d multi-hot cycles want 0", multi_hot); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
